pll_cen_gen: RTL
================

PLL_CEN_GEN -- requirements
Module: pll_cen_gen

Interface
REQ-001 SHALL take parameter NUM_CH, default 4: number of independent clock-enable channels (1..8).
REQ-002 SHALL take parameter ACC_W, default 16: phase-accumulator width per channel (8..32).
REQ-003 SHALL take parameter LOCK_HOLD, default 1024: cycles of continuous synchronised lock required before RUN (1..65535).
REQ-004 refclk  input  1  sole clock (PLL output domain); one clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pll_locked  input  1  raw PLL lock, asynchronous to refclk.
REQ-007 inc  input  NUM_CH*ACC_W  per-channel phase increment; channel n in bits [n*ACC_W +: ACC_W].
REQ-008 cen  output  NUM_CH  per-channel single-cycle clock-enable strobes.
REQ-009 ready  output  1  high only in RUN.
REQ-010 lock_lost  output  1  sticky flag: lock dropped while in RUN.

Function
REQ-011 SHALL pass pll_locked through a 2-flop synchroniser; lock_s is the second flop output; all decisions use lock_s.
REQ-012 SHALL implement states WAIT_LOCK, SETTLE, RUN, FAULT.
REQ-013 WAIT_LOCK: lock_s=1 -> SETTLE with settle counter cleared to 0.
REQ-014 SETTLE: counter increments each cycle lock_s=1; lock_s=0 -> WAIT_LOCK; counter reaching LOCK_HOLD-1 with lock_s=1 -> RUN.
REQ-015 RUN: lock_s=0 -> lock_lost set, then -> FAULT (macro absent) or WAIT_LOCK (macro present).
REQ-016 FAULT: terminal until rst; ready=0, cen=0.
REQ-017 Settle counter width SHALL be clog2(LOCK_HOLD)+1; no wrap possible.
REQ-018 In RUN, each channel SHALL compute {carry,acc} = acc + inc[n] at ACC_W+1 bits; acc <= low ACC_W bits; cen[n] <= carry (registered, one cycle after the carrying add).
REQ-019 Mean cen[n] rate SHALL be inc[n]/2^ACC_W of refclk; inc[n]=0 -> cen[n] never asserts.
REQ-020 inc changes SHALL take effect on the next add; accumulator not cleared.
REQ-021 Outside RUN, all accumulators SHALL be held at 0 and cen SHALL be 0 the same cycle the state leaves RUN.
REQ-022 ready SHALL be registered: high from the first RUN cycle, low the first cycle after leaving RUN.
REQ-023 Simultaneous lock_s drop and SETTLE terminal count: drop wins -> WAIT_LOCK.
REQ-024 lock_lost SHALL clear only on rst.

Reset
REQ-025 rst asserted (any time, incl. mid-RUN): state=WAIT_LOCK, synchroniser flops=0, settle counter=0, accumulators=0, cen=0, ready=0, lock_lost=0.
REQ-026 After rst deassertion, earliest RUN entry SHALL be 2 (sync) + 1 + LOCK_HOLD cycles with pll_locked held high.

Configuration
REQ-027 Macro PLL_CEN_AUTO_RELOCK_EN defined: loss of lock in RUN -> WAIT_LOCK; re-acquisition restarts SETTLE and RUN resumes with accumulators from 0; lock_lost still set.
REQ-028 Macro absent: loss of lock in RUN -> FAULT until rst; FAULT state is unreachable/omitted when macro defined.

Structure
REQ-029 Package pll_cen_pkg SHALL hold the state enum type and default parameter constants (NUM_CH, ACC_W, LOCK_HOLD defaults).
REQ-030 Sub-module pll_cen_sync (2-flop synchroniser, async reset to 0) SHALL be instantiated once for pll_locked.
REQ-031 Per-channel accumulators SHALL be generated by a loop over NUM_CH within pll_cen_gen.

Verification
REQ-032 ACC_W=16, LOCK_HOLD=8, pll_locked high from reset release -> ready rises exactly 11 cycles after rst deassert.
REQ-033 RUN, inc[0]=0x8000 -> cen[0] alternates 0,1 (1 pulse per 2 cycles); inc[1]=0x4000 -> 1 pulse per 4; inc[2]=0 -> none over 1000 cycles.
REQ-034 inc[3]=0x5555 over 3*2^16 cycles -> exactly 0xFFFF pulses (+-1).
REQ-035 pll_locked glitch low 1 cycle during SETTLE at count 5 -> WAIT_LOCK, full LOCK_HOLD restart, ready delayed accordingly.
REQ-036 pll_locked drops in RUN -> cen and ready 0 within 3 cycles, lock_lost=1; without macro stays in FAULT after relock; with macro ready returns 2+1+LOCK_HOLD cycles after relock.
REQ-037 rst pulsed mid-RUN -> all outputs 0 asynchronously, lock_lost cleared, normal restart sequence.

Source files
------------

// File: rtl/pll_cen_pkg.sv
// Shared types and default parameters for the PLL clock-enable generator.
// Optional auto-relock behaviour is selected in pll_cen_gen by PLL_CEN_AUTO_RELOCK_EN.
package pll_cen_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_LOCK_HOLD = 1024;

    // FAULT is only reachable when PLL_CEN_AUTO_RELOCK_EN is not defined.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } pll_state_e;

endpackage

// File: rtl/pll_cen_sync.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to 0.
module pll_cen_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_cen_gen.sv
// Lock-qualified multi-channel clock-enable generator (phase accumulators per channel).
// Define PLL_CEN_AUTO_RELOCK_EN to return to WAIT_LOCK on lock loss instead of latching FAULT.
module pll_cen_gen
    import pll_cen_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LOCK_HOLD = DEF_LOCK_HOLD
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    output logic [NUM_CH-1:0]       cen,
    output logic                    ready,
    output logic                    lock_lost,
    output pll_state_e              state
);

    localparam int               CNT_W    = $clog2(LOCK_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_HOLD - 1);

    logic             lock_s;
    logic [CNT_W-1:0] settle_cnt;
    logic             run_next;

    pll_cen_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    // A lock drop outranks the terminal count.
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (settle_cnt == CNT_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        lock_lost <= 1'b1;
                        ready     <= 1'b0;
`ifdef PLL_CEN_AUTO_RELOCK_EN
                        state     <= WAIT_LOCK;
`else
                        state     <= FAULT;
`endif
                    end
                end
                FAULT: begin
                    ready <= 1'b0;
                end
                default: begin
                    state <= WAIT_LOCK;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Accumulators advance only on edges where the FSM stays in RUN, so they
    // and cen clear on the very edge that leaves RUN.
    assign run_next = (state == RUN) && lock_s;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             cen_r;

        assign sum    = {1'b0, acc} + {1'b0, inc[n*ACC_W +: ACC_W]};
        assign cen[n] = cen_r;

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                acc   <= '0;
                cen_r <= 1'b0;
            end else if (run_next) begin
                acc   <= sum[ACC_W-1:0];
                cen_r <= sum[ACC_W];
            end else begin
                acc   <= '0;
                cen_r <= 1'b0;
            end
        end
    end

endmodule
